// File: rtl/vpe_ctrl_pkg.sv
// Shared types and constants for the VPE solve controller.
// Optional stochastic capture is enabled with the VPE_RANDOM_FLIP_EN macro.
package vpe_ctrl_pkg;

  localparam int NUM_VAR      = 60;
  localparam int NUM_CLAUSE   = 32;
  localparam int NUM_GRP      = 8;
  localparam int COLS_PER_GRP = 4;
  localparam int ITER_W       = 16;
  localparam int VAR_W        = 6;
  localparam int GRP_W        = 3;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_SETUP   = 3'd2,
    ST_UPDATE  = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  // Rows beyond the array decode to no word line at all.
  function automatic logic [NUM_VAR-1:0] wl_onehot(input logic [VAR_W-1:0] idx);
    logic [NUM_VAR-1:0] r;
    r = {NUM_VAR{1'b0}};
    if (idx < VAR_W'(NUM_VAR)) begin
      r[idx] = 1'b1;
    end else begin
      r = {NUM_VAR{1'b0}};
    end
    return r;
  endfunction

endpackage

// File: rtl/vpe_lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11), used only when VPE_RANDOM_FLIP_EN is defined.
module vpe_lfsr16
  import vpe_ctrl_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  output logic [15:0] state_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;
  logic        fb_s;

  assign fb_s = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  // Advance one step per enable.
  always_comb begin
    lfsr_d = lfsr_q;
    if (en_i) begin
      lfsr_d = {lfsr_q[14:0], fb_s};
    end else begin
      lfsr_d = lfsr_q;
    end
  end

  // LFSR state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/vpe_solve_ctrl.sv
// Load/solve sequencer for one VPE; owns all VPE strobes and the assignment vector.
// Define VPE_RANDOM_FLIP_EN to enable LFSR-driven stochastic flips at capture.
module vpe_solve_ctrl
  import vpe_ctrl_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [ITER_W-1:0]     max_iter_i,
  input  logic                  load_req_i,
  output logic                  load_ack_o,
  input  logic [VAR_W-1:0]      load_row_i,
  input  logic [GRP_W-1:0]      load_grp_i,
  input  logic                  load_sign_i,
  input  logic [3:0]            load_data_i,
  output logic [NUM_VAR-1:0]    wl_sw_o,
  output logic                  wl_sign_o,
  output logic [NUM_GRP-1:0]    bl_en_o,
  output logic [NUM_CLAUSE-1:0] bl_si_o,
  output logic [NUM_CLAUSE-1:0] bl_sl_o,
  output logic [NUM_CLAUSE-1:0] bl_sr_o,
  output logic                  sram_state_o,
  output logic                  vul_en_o,
  output logic                  var_state_o,
  output logic                  v_pre_o,
  output logic [NUM_VAR-1:0]    v_o,
  input  logic                  vi_readout_i,
  input  logic                  satisfy_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  sat_found_o,
  output logic [ITER_W-1:0]     iter_cnt_o
);

  state_e                state_q, state_d;
  logic [VAR_W-1:0]      var_idx_q, var_idx_d;
  logic [ITER_W-1:0]     iter_cnt_q, iter_cnt_d;
  logic [ITER_W-1:0]     max_iter_q, max_iter_d;
  logic [NUM_VAR-1:0]    assign_q, assign_d;
  logic                  done_q, done_d;
  logic                  sat_q, sat_d;

  logic                  load_ack_q, load_ack_d;
  logic [NUM_VAR-1:0]    wl_sw_q, wl_sw_d;
  logic                  wl_sign_q, wl_sign_d;
  logic [NUM_GRP-1:0]    bl_en_q, bl_en_d;
  logic [NUM_CLAUSE-1:0] bl_si_q, bl_si_d;
  logic                  sram_q, sram_d;
  logic                  vul_en_q, vul_en_d;
  logic                  var_state_q, var_state_d;
  logic                  v_pre_q, v_pre_d;
  logic                  busy_q, busy_d;

  logic                  cap_bit_s;
  logic                  last_var_s;
  logic [ITER_W-1:0]     iter_inc_s;
  logic                  budget_hit_s;

`ifdef VPE_RANDOM_FLIP_EN
  logic [15:0] lfsr_s;

  vpe_lfsr16 u_lfsr (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .en_i    (state_q == ST_CAPTURE),
    .state_o (lfsr_s)
  );

  assign cap_bit_s = vi_readout_i ^ (lfsr_s[3:0] == 4'd0);
`else
  assign cap_bit_s = vi_readout_i;
`endif

  assign last_var_s   = (var_idx_q == VAR_W'(NUM_VAR - 1));
  assign iter_inc_s   = (&iter_cnt_q) ? iter_cnt_q : iter_cnt_q + ITER_W'(1);
  assign budget_hit_s = (max_iter_q != {ITER_W{1'b0}}) && (iter_inc_s == max_iter_q);

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      var_idx_q  <= {VAR_W{1'b0}};
      iter_cnt_q <= {ITER_W{1'b0}};
      max_iter_q <= {ITER_W{1'b0}};
      assign_q   <= {NUM_VAR{1'b0}};
      done_q     <= 1'b0;
      sat_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      var_idx_q  <= var_idx_d;
      iter_cnt_q <= iter_cnt_d;
      max_iter_q <= max_iter_d;
      assign_q   <= assign_d;
      done_q     <= done_d;
      sat_q      <= sat_d;
    end
  end

  // Next-state and datapath update; load wins over start when both arrive.
  always_comb begin
    state_d    = state_q;
    var_idx_d  = var_idx_q;
    iter_cnt_d = iter_cnt_q;
    max_iter_d = max_iter_q;
    assign_d   = assign_q;
    done_d     = done_q;
    sat_d      = sat_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (load_req_i) begin
          state_d = ST_LOAD;
        end else if (start_i) begin
          state_d    = ST_SETUP;
          var_idx_d  = {VAR_W{1'b0}};
          iter_cnt_d = {ITER_W{1'b0}};
          max_iter_d = max_iter_i;
          done_d     = 1'b0;
          sat_d      = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      ST_LOAD:   state_d = ST_IDLE;
      ST_SETUP:  state_d = ST_UPDATE;
      ST_UPDATE: state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        assign_d[var_idx_q] = cap_bit_s;
        if (satisfy_i) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          sat_d   = 1'b1;
        end else if (!last_var_s) begin
          state_d   = ST_SETUP;
          var_idx_d = var_idx_q + VAR_W'(1);
        end else begin
          var_idx_d  = {VAR_W{1'b0}};
          iter_cnt_d = iter_inc_s;
          if (budget_hit_s) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            sat_d   = 1'b0;
          end else begin
            state_d = ST_SETUP;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Strobe decode from the state being entered so the registered strobes line up with it.
  always_comb begin
    load_ack_d  = 1'b0;
    wl_sw_d     = {NUM_VAR{1'b0}};
    wl_sign_d   = 1'b0;
    bl_en_d     = {NUM_GRP{1'b0}};
    bl_si_d     = {NUM_CLAUSE{1'b0}};
    sram_d      = 1'b0;
    vul_en_d    = 1'b0;
    var_state_d = 1'b0;
    v_pre_d     = 1'b0;
    busy_d      = 1'b0;
    case (state_d)
      ST_LOAD: begin
        load_ack_d = 1'b1;
        wl_sw_d    = wl_onehot(load_row_i);
        wl_sign_d  = load_sign_i;
        bl_en_d    = NUM_GRP'(1) << load_grp_i;
        bl_si_d    = NUM_CLAUSE'(load_data_i) << {load_grp_i, 2'b00};
        sram_d     = 1'b1;
        busy_d     = 1'b1;
      end
      ST_SETUP, ST_UPDATE, ST_CAPTURE: begin
        wl_sw_d     = wl_onehot(var_idx_d);
        var_state_d = 1'b1;
        v_pre_d     = assign_d[var_idx_d];
        vul_en_d    = (state_d == ST_UPDATE);
        busy_d      = 1'b1;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // Output strobe registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      load_ack_q  <= 1'b0;
      wl_sw_q     <= {NUM_VAR{1'b0}};
      wl_sign_q   <= 1'b0;
      bl_en_q     <= {NUM_GRP{1'b0}};
      bl_si_q     <= {NUM_CLAUSE{1'b0}};
      sram_q      <= 1'b0;
      vul_en_q    <= 1'b0;
      var_state_q <= 1'b0;
      v_pre_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      load_ack_q  <= load_ack_d;
      wl_sw_q     <= wl_sw_d;
      wl_sign_q   <= wl_sign_d;
      bl_en_q     <= bl_en_d;
      bl_si_q     <= bl_si_d;
      sram_q      <= sram_d;
      vul_en_q    <= vul_en_d;
      var_state_q <= var_state_d;
      v_pre_q     <= v_pre_d;
      busy_q      <= busy_d;
    end
  end

  assign load_ack_o   = load_ack_q;
  assign wl_sw_o      = wl_sw_q;
  assign wl_sign_o    = wl_sign_q;
  assign bl_en_o      = bl_en_q;
  assign bl_si_o      = bl_si_q;
  assign bl_sl_o      = {NUM_CLAUSE{1'b0}};
  assign bl_sr_o      = {NUM_CLAUSE{1'b0}};
  assign sram_state_o = sram_q;
  assign vul_en_o     = vul_en_q;
  assign var_state_o  = var_state_q;
  assign v_pre_o      = v_pre_q;
  assign v_o          = assign_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign sat_found_o  = sat_q;
  assign iter_cnt_o   = iter_cnt_q;

endmodule

// File: tb/tb_vpe_solve_ctrl.sv
// Directed self-checking bench for vpe_solve_ctrl (default build, no random flips).
module tb_vpe_solve_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] max_iter;
  logic        load_req;
  logic        load_ack;
  logic [5:0]  load_row;
  logic [2:0]  load_grp;
  logic        load_sign;
  logic [3:0]  load_data;
  logic [59:0] wl_sw;
  logic        wl_sign;
  logic [7:0]  bl_en;
  logic [31:0] bl_si, bl_sl, bl_sr;
  logic        sram_state, vul_en, var_state, v_pre;
  logic [59:0] v;
  logic        vi_readout, satisfy;
  logic        busy, done, sat_found;
  logic [15:0] iter_cnt;

  int tests = 0;
  int fails = 0;

  vpe_solve_ctrl dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .max_iter_i   (max_iter),
    .load_req_i   (load_req),
    .load_ack_o   (load_ack),
    .load_row_i   (load_row),
    .load_grp_i   (load_grp),
    .load_sign_i  (load_sign),
    .load_data_i  (load_data),
    .wl_sw_o      (wl_sw),
    .wl_sign_o    (wl_sign),
    .bl_en_o      (bl_en),
    .bl_si_o      (bl_si),
    .bl_sl_o      (bl_sl),
    .bl_sr_o      (bl_sr),
    .sram_state_o (sram_state),
    .vul_en_o     (vul_en),
    .var_state_o  (var_state),
    .v_pre_o      (v_pre),
    .v_o          (v),
    .vi_readout_i (vi_readout),
    .satisfy_i    (satisfy),
    .busy_o       (busy),
    .done_o       (done),
    .sat_found_o  (sat_found),
    .iter_cnt_o   (iter_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic any_out();
    return |{load_ack, wl_sw, wl_sign, bl_en, bl_si, bl_sl, bl_sr, sram_state, vul_en,
             var_state, v_pre, v, busy, done, sat_found, iter_cnt};
  endfunction

  logic [59:0] one60;
  logic [59:0] model;
  int cyc, vul_cnt, guard;

  initial begin
    one60 = 60'd1;
    rst_n = 1'b0; start = 1'b0; max_iter = 16'd0; load_req = 1'b0;
    load_row = 6'd0; load_grp = 3'd0; load_sign = 1'b0; load_data = 4'd0;
    vi_readout = 1'b0; satisfy = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs_zero", 64'(any_out()), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", 64'(busy), 64'd0);

    // Load row 5, group 3, data 1010.
    load_req = 1'b1; load_row = 6'd5; load_grp = 3'd3; load_sign = 1'b1; load_data = 4'b1010;
    @(negedge clk);
    load_req = 1'b0;
    chk("load_wl_sw", 64'(wl_sw), 64'(one60 << 5));
    chk("load_bl_en", 64'(bl_en), 64'h08);
    chk("load_bl_si", 64'(bl_si), 64'h0000_A000);
    chk("load_sram", 64'(sram_state), 64'd1);
    chk("load_ack", 64'(load_ack), 64'd1);
    chk("load_sign", 64'(wl_sign), 64'd1);
    chk("load_no_vul", 64'({vul_en, var_state}), 64'd0);
    @(negedge clk);
    chk("load_ack_drop", 64'({load_ack, sram_state, busy}), 64'd0);
    chk("load_wl_off", 64'(wl_sw), 64'd0);

    // Out-of-range row: ack but no word line.
    load_req = 1'b1; load_row = 6'd62; load_grp = 3'd0; load_sign = 1'b0; load_data = 4'hF;
    @(negedge clk);
    load_req = 1'b0;
    chk("oor_wl_sw", 64'(wl_sw), 64'd0);
    chk("oor_ack", 64'(load_ack), 64'd1);
    chk("oor_bl_si", 64'(bl_si), 64'h0000_000F);
    @(negedge clk);

    // LOAD_REQ and START together: load first, start dropped.
    load_req = 1'b1; start = 1'b1; load_row = 6'd1; load_grp = 3'd7; load_data = 4'h3;
    @(negedge clk);
    load_req = 1'b0; start = 1'b0;
    chk("prio_load", 64'({sram_state, load_ack, var_state}), 64'b110);
    chk("prio_bl_si", 64'(bl_si), 64'h3000_0000);
    @(negedge clk);
    chk("prio_idle", 64'({busy, var_state}), 64'd0);
    @(negedge clk);
    chk("prio_no_start", 64'({busy, var_state, wl_sw}), 64'd0);

    // Immediate satisfy.
    satisfy = 1'b1; vi_readout = 1'b1; max_iter = 16'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("sat_setup", 64'({var_state, vul_en, busy, v_pre}), 64'b1010);
    chk("sat_setup_wl", 64'(wl_sw), 64'(one60));
    @(negedge clk);
    chk("sat_update_vul", 64'(vul_en), 64'd1);
    @(negedge clk);
    chk("sat_capture_vul", 64'(vul_en), 64'd0);
    chk("sat_capture_done", 64'(done), 64'd0);
    @(negedge clk);
    chk("sat_done", 64'({done, sat_found, busy}), 64'b110);
    chk("sat_assign", 64'(v), 64'd1);
    chk("sat_iter", 64'(iter_cnt), 64'd0);
    chk("sat_strobes_off", 64'({var_state, vul_en, wl_sw}), 64'd0);

    // Budget exhaustion with a START pulse injected mid-solve.
    satisfy = 1'b0; vi_readout = 1'b0; max_iter = 16'd2; start = 1'b1;
    cyc = 0; vul_cnt = 0;
    for (guard = 0; guard < 1000; guard++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) cyc++;
      if (vul_en) vul_cnt++;
      if (cyc == 181 && busy) chk("budget_iter_mid", 64'(iter_cnt), 64'd1);
      if (cyc == 200 && busy) start = 1'b1;
      if (done) break;
    end
    chk("budget_timeout", 64'(guard < 1000), 64'd1);
    chk("budget_cycles", 64'(cyc), 64'd360);
    chk("budget_vul", 64'(vul_cnt), 64'd120);
    chk("budget_done", 64'({done, sat_found}), 64'b10);
    chk("budget_iter", 64'(iter_cnt), 64'd2);
    chk("budget_assign", 64'(v), 64'd0);
    start = 1'b0;

    // Reset in the middle of a sweep.
    vi_readout = 1'b1; max_iter = 16'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (guard = 0; guard < 200; guard++) begin
      if (wl_sw === (one60 << 30)) break;
      @(negedge clk);
    end
    chk("mid_reach_30", 64'(guard < 200), 64'd1);
    chk("mid_assign", 64'(v), 64'h3FFF_FFFF);
    #1 rst_n = 1'b0;
    #1 chk("mid_async_zero", 64'(any_out()), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // One sweep with VI_READOUT = ~V_PRE (from the bench model) from ASSIGN = 0.
    model = 60'd0; max_iter = 16'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 60; k++) begin
      chk($sformatf("cap_wl_%0d", k), 64'(wl_sw), 64'(one60 << k));
      chk($sformatf("cap_vpre_%0d", k), 64'(v_pre), 64'(model[k]));
      vi_readout = ~model[k];
      model[k] = ~model[k];
      repeat (3) @(negedge clk);
    end
    chk("cap_done", 64'({done, sat_found}), 64'b10);
    chk("cap_assign", 64'(v), 64'h0FFF_FFFF_FFFF_FFFF);
    chk("cap_iter", 64'(iter_cnt), 64'd1);

    // Resume from DONE keeps ASSIGN.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("resume_done_clr", 64'({done, busy}), 64'b01);
    chk("resume_vpre", 64'(v_pre), 64'(model[0]));
    chk("resume_iter", 64'(iter_cnt), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vpe_solve_ctrl.md
Name: vpe_solve_ctrl

Overview:
- Sequencer for one variable-processing element (VPE): 60 variables × 32 clause columns, with a per-variable update unit and a SATISFY chain input.
- Two phases:
  - Load: writes clause SRAM rows through a loader handshake.
  - Solve: sweeps all variables and performs one update per variable.
- Stops when SATISFY is seen or the iteration budget runs out.
- Sits between the top-level host/sequencer and the VPE. Owns every VPE control strobe plus the variable assignment vector.

Parameters:
- NUM_VAR, 60, variables per VPE (word-line rows).
- NUM_GRP, 8, bit-line enable groups (4 clause columns each).
- ITER_W, 16, width of the sweep counter and of MAX_ITER.

Ports:
- CLK  in  1  clock.
- RESET_N  in  1  asynchronous, active-low reset.
- START  in  1  one-cycle pulse; begins a solve when IDLE.
- MAX_ITER  in  ITER_W  sweep budget, sampled on START.
- LOAD_REQ  in  1  loader requests one SRAM write.
- LOAD_ACK  out  1  one-cycle acknowledge; the write was issued.
- LOAD_ROW  in  6  target variable row, 0..NUM_VAR-1.
- LOAD_GRP  in  3  target bit-line group.
- LOAD_SIGN  in  1  literal polarity.
- LOAD_DATA  in  4  bits for the 4 columns of the group.
- WL_SW  out  NUM_VAR  one-hot word-line select, 0 when inactive.
- WL_SIGN  out  1  polarity to the VPE.
- BL_EN  out  NUM_GRP  one-hot group enable.
- BL_SI  out  32  write data: LOAD_DATA placed at columns 4·GRP..4·GRP+3, 0 elsewhere.
- BL_SL, BL_SR  out  32  tied 0 (reserved).
- SRAM_STATE  out  1  1 = write mode.
- VUL_EN  out  1  variable-update enable.
- VAR_STATE  out  1  1 during the solve phase.
- V_PRE  out  1  previous value of the selected variable.
- V  out  NUM_VAR  current assignment vector (ASSIGN register).
- VI_READOUT  in  1  updated value of the selected variable.
- SATISFY  in  1  all clauses satisfied.
- BUSY  out  1  not IDLE/DONE.
- DONE  out  1  level, held until next START.
- SAT_FOUND  out  1  valid when DONE.
- ITER_CNT  out  ITER_W  completed sweeps.

Behaviour:
- Reset: state IDLE. All outputs 0, including ASSIGN, counters, LOAD_ACK, DONE and SAT_FOUND.
- States: IDLE, LOAD, SETUP, UPDATE, CAPTURE, DONE.
- IDLE:
  - LOAD_REQ=1 → LOAD (START is ignored that cycle; load has priority).
  - Else START=1 → SETUP, with var_idx=0 and ITER_CNT=0. MAX_ITER is latched and DONE/SAT_FOUND are cleared.
- LOAD, one cycle:
  - SRAM_STATE=1.
  - WL_SW=1<<LOAD_ROW, WL_SIGN=LOAD_SIGN.
  - BL_EN=1<<LOAD_GRP, BL_SI as defined under Ports.
  - LOAD_ACK=1. Return to IDLE.
  - LOAD_ROW≥NUM_VAR: WL_SW=0 and no write, but LOAD_ACK is still given.
  - LOAD_REQ is also accepted from DONE.
- SETUP:
  - VAR_STATE=1, WL_SW=1<<var_idx.
  - V_PRE=ASSIGN[var_idx].
  - → UPDATE.
- UPDATE:
  - Same drives as SETUP, plus VUL_EN=1 for exactly one cycle.
  - → CAPTURE.
- CAPTURE:
  - ASSIGN[var_idx] ← VI_READOUT.
  - If SATISFY=1 → DONE with SAT_FOUND=1. SATISFY is sampled in CAPTURE only.
  - Else, if var_idx<NUM_VAR-1: var_idx+1 → SETUP.
  - Else (end of sweep): var_idx=0 and ITER_CNT+1.
    - If ITER_CNT+1==MAX_ITER → DONE with SAT_FOUND=0.
    - Otherwise → SETUP.
- MAX_ITER=0 means unlimited sweeps. ITER_CNT saturates at all-ones.
- Per-variable latency is 3 cycles. One sweep is 3·NUM_VAR = 180 cycles.
- DONE:
  - DONE=1, BUSY=0. ASSIGN is held.
  - START → new solve. ASSIGN is not cleared; the solve resumes from the current assignment.
- START while BUSY is ignored.
- Asynchronous reset mid-solve returns to IDLE immediately and clears ASSIGN.
- WL_SW, BL_EN, SRAM_STATE, VUL_EN and VAR_STATE are all registered, decoded from next-state. They are glitch-free and never active together across LOAD/solve.

Optional Feature:
- Macro VPE_RANDOM_FLIP_EN.
- When defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1 on reset) advances every CAPTURE. If lfsr[3:0]==0, ASSIGN[var_idx] ← ~VI_READOUT (stochastic escape from local minima). SATISFY is still sampled in the same CAPTURE.
- When undefined: capture is deterministic and no LFSR logic is present.

Decomposition:
- Package vpe_ctrl_pkg holds:
  - state enum (IDLE, LOAD, SETUP, UPDATE, CAPTURE, DONE);
  - constants NUM_VAR=60, NUM_CLAUSE=32, NUM_GRP=8, COLS_PER_GRP=4, LFSR_SEED.
- Sub-module vpe_lfsr16 (enable, 16-bit state out), instantiated only under VPE_RANDOM_FLIP_EN.

Test Plan:
- Load: LOAD_REQ with ROW=5, GRP=3, SIGN=1, DATA=4'b1010 → one cycle with WL_SW=1<<5, BL_EN=8'h08, BL_SI=32'h0000_A000, SRAM_STATE=1, LOAD_ACK=1; then IDLE.
- Immediate satisfy: SATISFY tied 1, START with MAX_ITER=4 → DONE=1, SAT_FOUND=1 on the cycle after the first CAPTURE; ASSIGN[0]=VI_READOUT; ITER_CNT=0.
- Budget exhaustion: SATISFY=0, MAX_ITER=2 → DONE after 360 cycles of solve, SAT_FOUND=0, ITER_CNT=2; VUL_EN pulsed exactly 120 times.
- V_PRE/capture: VI_READOUT=~V_PRE model, ASSIGN starting at 0, one sweep → ASSIGN=all-ones; V_PRE for var k equals the prior ASSIGN[k].
- Priority/ignore: LOAD_REQ and START together in IDLE → LOAD first, START dropped. START while BUSY → no restart and ITER_CNT continues.
- Reset mid-sweep: RESET_N low at var_idx=30 → all outputs 0 asynchronously; after release the next START sweeps from var 0.
